// File: rtl/frame_sync_inserter_pkg.sv
// Shared definitions for the transmit-side sync inserter and the receive-side
// frame synchronizer, so both ends of the link agree on framing.
package frame_sync_inserter_pkg;

   // Framing FSM states, common to inserter and synchronizer
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SYNC    = 2'd1,
      PAYLOAD = 2'd2,
      PAD     = 2'd3
   } fsi_state_t;

   // Payload bits per frame: 32 data bits carried as Hamming(7,4)
   localparam int FRAME_BITS_DEF = 56;

   // Barker-7 sync word, transmitted MSB first
   localparam int SYNC_LEN_DEF = 7;
   localparam logic [SYNC_LEN_DEF-1:0] SYNC_WORD_DEF = 7'b1110010;

   // Idle cycles tolerated inside a payload before zero padding starts
   localparam int PAD_TIMEOUT_DEF = 16;

   // Width of the completed-frame counter
   localparam int CNT_W_DEF = 16;

   // Counter width able to index 0..n-1, never narrower than one bit
   function automatic int idx_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/frame_sync_inserter.sv
// Frame sync inserter: prepends the sync word to every payload of FRAME_BITS
// encoded bits and pads stalled frames with zeros so the receiver's frame
// timing is never broken.
module frame_sync_inserter
   import frame_sync_inserter_pkg::*;
#(
   parameter int                  FRAME_BITS  = FRAME_BITS_DEF,
   parameter int                  SYNC_LEN    = SYNC_LEN_DEF,
   parameter logic [SYNC_LEN-1:0] SYNC_WORD   = SYNC_WORD_DEF,
   parameter int                  PAD_TIMEOUT = PAD_TIMEOUT_DEF,
   parameter int                  CNT_W       = CNT_W_DEF
) (
   input  logic             clk_out,
   input  logic             rst,
   input  logic             data_in,
   input  logic             data_valid,
   output logic             data_in_ready,
   output logic             data_out,
   output logic             data_out_valid,
   output logic             frame_start,
   output logic             frame_padded,
   output logic [CNT_W-1:0] frame_count
);

   localparam int SIDX_W = idx_width(SYNC_LEN);
   localparam int PAY_W  = idx_width(FRAME_BITS);
   localparam int GAP_W  = idx_width(PAD_TIMEOUT);

   localparam logic [SIDX_W-1:0] SYNC_LAST = SIDX_W'(SYNC_LEN - 1);
   localparam logic [PAY_W-1:0]  PAY_LAST  = PAY_W'(FRAME_BITS - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(PAD_TIMEOUT - 1);

   fsi_state_t          state;
   logic [SIDX_W-1:0]   sync_idx;
   logic [SYNC_LEN-1:0] sync_sr;
   logic [PAY_W-1:0]    pay_cnt;
   logic [GAP_W-1:0]    gap;

   // Upstream may only hand over bits while a payload is being collected
   assign data_in_ready = (state == PAYLOAD);

   // Framing FSM: sync word, payload pass-through with stall gaps, zero pad
   always_ff @(posedge clk_out or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         sync_idx       <= '0;
         sync_sr        <= '0;
         pay_cnt        <= '0;
         gap            <= '0;
         data_out       <= 1'b0;
         data_out_valid <= 1'b0;
         frame_start    <= 1'b0;
         frame_padded   <= 1'b0;
         frame_count    <= '0;
      end else begin
         frame_start  <= 1'b0;
         frame_padded <= 1'b0;
         unique case (state)
            IDLE: begin
               data_out_valid <= 1'b0;
               if (data_valid) begin
                  state    <= SYNC;
                  sync_idx <= '0;
                  sync_sr  <= SYNC_WORD;
               end
            end
            SYNC: begin
               data_out       <= sync_sr[SYNC_LEN-1];
               data_out_valid <= 1'b1;
               sync_sr        <= sync_sr << 1;
               frame_start    <= (sync_idx == '0);
               if (sync_idx == SYNC_LAST) begin
                  state   <= PAYLOAD;
                  pay_cnt <= '0;
                  gap     <= '0;
               end else begin
                  sync_idx <= sync_idx + 1'b1;
               end
            end
            PAYLOAD: begin
               if (data_valid) begin
                  data_out       <= data_in;
                  data_out_valid <= 1'b1;
                  gap            <= '0;
                  pay_cnt        <= pay_cnt + 1'b1;
                  if (pay_cnt == PAY_LAST) begin
                     frame_count <= frame_count + 1'b1;
                     state       <= IDLE;
                  end
               end else begin
                  data_out_valid <= 1'b0;
                  gap            <= gap + 1'b1;
                  if (gap == GAP_LAST) begin
                     state <= PAD;
                  end
               end
            end
            PAD: begin
               data_out       <= 1'b0;
               data_out_valid <= 1'b1;
               pay_cnt        <= pay_cnt + 1'b1;
               if (pay_cnt == PAY_LAST) begin
                  frame_padded <= 1'b1;
                  frame_count  <= frame_count + 1'b1;
                  state        <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frame_sync_inserter.sv
// Testbench for frame_sync_inserter: drives encoded payload frames with random
// stalls, abandoned frames and resets, and compares the framed output stream
// against a queue of expected wire bits built from the framing rules.
module tb_frame_sync_inserter;
   import frame_sync_inserter_pkg::*;

   localparam int FB = 56;
   localparam int SL = 7;
   localparam int PT = 16;
   localparam logic [6:0] SW = 7'b1110010;

   logic        clk_out = 1'b0;
   logic        rst;
   logic        data_in;
   logic        data_valid;
   logic        data_in_ready;
   logic        data_out;
   logic        data_out_valid;
   logic        frame_start;
   logic        frame_padded;
   logic [15:0] frame_count;

   frame_sync_inserter dut (
      .clk_out        (clk_out),
      .rst            (rst),
      .data_in        (data_in),
      .data_valid     (data_valid),
      .data_in_ready  (data_in_ready),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .frame_start    (frame_start),
      .frame_padded   (frame_padded),
      .frame_count    (frame_count)
   );

   // Bitstream clock, 10 time units per cycle
   always #5 clk_out = ~clk_out;

   // One expected valid bit on the wire, with its side-band expectations
   typedef struct {
      logic b;
      logic start;
      logic padlast;
      logic last;
      int   gap;
      int   count;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   model_frames = 0;
   int   ready_cycles = 0;
   int   cyc = 0;
   int   last_start = -1;
   int   prev_start = -1;
   logic cur_bits[FB];
   int   cur_gaps[FB];

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic pushItem(input logic b, input logic start, input logic padlast, input logic last, input int gap);
      exp_t it;
      it.b       = b;
      it.start   = start;
      it.padlast = padlast;
      it.last    = last;
      it.gap     = gap;
      if (last) model_frames++;
      it.count   = model_frames % 65536;
      exp_q.push_back(it);
   endtask

   task automatic waitDrain();
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 400) begin
         @(posedge clk_out);
         #1;
         w++;
      end
      checkOutput("drain", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic handshake();
      int  waited;
      bit  acc;
      waited = 0;
      do begin
         acc = data_in_ready;
         @(posedge clk_out);
         #1;
         waited++;
      end while (!acc && waited < 200);
      if (!acc) checkOutput("handshake_timeout", 0, 1);
   endtask

   // mode 0: full frame, mode 1: upstream abandons after stop_at bits,
   // mode 2: reset asserted between edges after stop_at bits
   task automatic applyStimulus(input int mode, input int stop_at, input bit sync_drop, input bit back_to_back);
      logic [6:0] sw;
      int n_seen;
      int n_send;
      sw     = SW;
      n_send = (mode == 0) ? FB : stop_at;
      n_seen = (mode == 0) ? FB : (mode == 1) ? stop_at : stop_at - 1;
      for (int i = 0; i < SL; i++)
         pushItem(sw[SL-1-i], (i == 0), 1'b0, 1'b0, (i == 0) ? (back_to_back ? 1 : -1) : 0);
      for (int i = 0; i < n_seen; i++)
         pushItem(cur_bits[i], 1'b0, 1'b0, (mode == 0 && i == FB-1), (i == 0) ? 0 : cur_gaps[i]);
      if (mode == 1)
         for (int i = stop_at; i < FB; i++)
            pushItem(1'b0, 1'b0, (i == FB-1), (i == FB-1), (i == stop_at) ? PT : 0);

      data_in    = cur_bits[0];
      data_valid = 1'b1;
      if (sync_drop) begin
         @(posedge clk_out);
         #1;
         data_valid = 1'b0;
         data_in    = 1'($urandom);
         repeat (3) begin
            @(posedge clk_out);
            #1;
         end
         data_valid = 1'b1;
         data_in    = cur_bits[0];
      end
      for (int i = 0; i < n_send; i++) begin
         if (i > 0 && cur_gaps[i] > 0) begin
            data_valid = 1'b0;
            data_in    = 1'($urandom);
            repeat (cur_gaps[i]) begin
               @(posedge clk_out);
               #1;
            end
         end
         data_valid = 1'b1;
         data_in    = cur_bits[i];
         handshake();
      end
      data_valid = 1'b0;

      if (mode == 1) begin
         waitDrain();
      end else if (mode == 2) begin
         #2;
         rst = 1'b1;
         #1;
         checkOutput("rst_data_out", data_out, 0);
         checkOutput("rst_valid", data_out_valid, 0);
         checkOutput("rst_frame_start", frame_start, 0);
         checkOutput("rst_frame_padded", frame_padded, 0);
         checkOutput("rst_frame_count", frame_count, 0);
         checkOutput("rst_ready", data_in_ready, 0);
         checkOutput("bits_before_reset", exp_q.size(), 0);
         exp_q.delete();
         model_frames = 0;
         repeat (2) @(posedge clk_out);
         #1;
         rst = 1'b0;
      end
   endtask

   function automatic logic [6:0] hamming74(input logic [3:0] d);
      logic p1, p2, p3;
      p1 = d[3] ^ d[2] ^ d[0];
      p2 = d[3] ^ d[1] ^ d[0];
      p3 = d[2] ^ d[1] ^ d[0];
      return {p1, p2, d[3], p3, d[2], d[1], d[0]};
   endfunction

   task automatic loadEncoded(input logic [31:0] word);
      logic [6:0] cw;
      for (int n = 0; n < 8; n++) begin
         cw = hamming74(word[31-4*n -: 4]);
         for (int k = 0; k < 7; k++) cur_bits[7*n+k] = cw[6-k];
      end
      for (int i = 0; i < FB; i++) cur_gaps[i] = 0;
   endtask

   task automatic loadRandom();
      for (int i = 0; i < FB; i++) begin
         cur_bits[i] = 1'($urandom);
         cur_gaps[i] = 0;
      end
   endtask

   // Output monitor: pops one expected bit per valid output cycle
   initial begin : monitor
      int   idle_run;
      exp_t it;
      idle_run = 0;
      forever begin
         @(negedge clk_out);
         cyc++;
         if (data_in_ready) ready_cycles++;
         if (frame_start) begin
            prev_start = last_start;
            last_start = cyc;
         end
         if (data_out_valid) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_bit", 1, 0);
            end else begin
               it = exp_q.pop_front();
               checkOutput("data_out", data_out, it.b);
               checkOutput("frame_start", frame_start, it.start);
               checkOutput("frame_padded", frame_padded, it.padlast);
               if (it.gap >= 0) checkOutput("gap_before_bit", idle_run, it.gap);
               if (it.last) checkOutput("frame_count", frame_count, it.count);
            end
            idle_run = 0;
         end else begin
            checkOutput("pulse_without_valid", {frame_start, frame_padded}, 0);
            idle_run++;
         end
      end
   end

   // Hard stop in case anything above fails to terminate
   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main stimulus sequence
   initial begin : stimulus
      int r0;
      bit prev_normal;
      int mode;
      rst        = 1'b1;
      data_in    = 1'b0;
      data_valid = 1'b0;
      repeat (2) @(posedge clk_out);
      #1;
      checkOutput("reset_data_out", data_out, 0);
      checkOutput("reset_valid", data_out_valid, 0);
      checkOutput("reset_frame_start", frame_start, 0);
      checkOutput("reset_frame_padded", frame_padded, 0);
      checkOutput("reset_frame_count", frame_count, 0);
      checkOutput("reset_ready", data_in_ready, 0);
      rst = 1'b0;
      repeat (2) @(posedge clk_out);
      #1;

      $display("[TB] continuous frame of encoded 0xFC618790");
      loadEncoded(32'hFC61_8790);
      r0 = ready_cycles;
      applyStimulus(0, FB, 1'b0, 1'b0);
      waitDrain();
      checkOutput("ready_cycles", ready_cycles - r0, FB);

      $display("[TB] two frames back to back");
      loadRandom();
      applyStimulus(0, FB, 1'b0, 1'b0);
      loadEncoded(32'h1234_ABCD);
      applyStimulus(0, FB, 1'b0, 1'b1);
      waitDrain();
      checkOutput("start_spacing", last_start - prev_start, SL + FB + 1);

      $display("[TB] 15-cycle stall after payload bit 20");
      loadRandom();
      cur_gaps[20] = PT - 1;
      applyStimulus(0, FB, 1'b0, 1'b0);
      waitDrain();

      $display("[TB] upstream abandons after payload bit 20");
      loadRandom();
      applyStimulus(1, 20, 1'b0, 1'b0);

      $display("[TB] reset during payload bit 30");
      loadRandom();
      applyStimulus(2, 30, 1'b0, 1'b0);
      repeat (2) @(posedge clk_out);
      #1;
      loadRandom();
      applyStimulus(0, FB, 1'b0, 1'b0);
      waitDrain();

      $display("[TB] randomized frames");
      prev_normal = 1'b0;
      for (int f = 0; f < 12; f++) begin
         loadRandom();
         for (int i = 1; i < FB; i++)
            if ($urandom_range(0, 7) == 0) cur_gaps[i] = $urandom_range(1, PT - 1);
         if ($urandom_range(0, 2) == 0) cur_gaps[$urandom_range(1, FB - 1)] = PT - 1;
         mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
         if (prev_normal && $urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 4)) begin
               @(posedge clk_out);
               #1;
            end
            prev_normal = 1'b0;
         end
         applyStimulus(mode, $urandom_range(1, FB - 1), ($urandom_range(0, 3) == 0), prev_normal);
         prev_normal = (mode == 0);
      end
      waitDrain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/frame_sync_inserter.md
Name: frame_sync_inserter

Overview:
- Transmit-side partner of the receive-path frame synchronizer.
- Takes the serial Hamming-encoded bitstream from the encoder with a valid/ready handshake.
- Prepends a fixed sync word before every FRAME_BITS payload bits and emits a framed serial stream toward the channel / error-injection stage.
- If the upstream stalls mid-frame for too long, pads the frame with zeros so the receiver's frame timing is never broken.

Parameters:
- FRAME_BITS, 56: payload bits per frame (32 data bits encoded as Hamming(7,4)).
- SYNC_LEN, 7: sync word length in bits.
- SYNC_WORD, 7'b1110010: sync pattern (Barker-7), sent MSB first.
- PAD_TIMEOUT, 16: consecutive idle cycles inside a payload before zero padding starts.
- CNT_W, 16: frame counter width.

Ports:
- clk_out  in  1  bitstream clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  1  encoded payload bit.
- data_valid  in  1  data_in is valid. Upstream holds data_in stable while data_valid=1 and data_in_ready=0.
- data_in_ready  out  1  block accepts data_in this cycle.
- data_out  out  1  framed serial bit (registered).
- data_out_valid  out  1  data_out carries a sync, payload or pad bit (registered).
- frame_start  out  1  one-cycle pulse, coincident with sync bit 0 on data_out.
- frame_padded  out  1  one-cycle pulse, coincident with the last pad bit of a padded frame.
- frame_count  out  CNT_W  completed frames (normal or padded); wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, any state): state=IDLE. data_out, data_out_valid, frame_start and frame_padded all 0. frame_count=0. Internal sync/payload/gap counters 0. Any partial frame is discarded; no pad is sent.
- data_in_ready is Moore: it is 1 only in state PAYLOAD. A transfer occurs when data_valid & data_in_ready at a rising edge.
- IDLE:
  - data_out_valid<=0.
  - If data_valid=1 at an edge, next state is SYNC with sync_idx=0. Nothing is consumed.
- SYNC:
  - Each edge: data_out<=SYNC_WORD[SYNC_LEN-1-sync_idx], data_out_valid<=1, sync_idx++.
  - frame_start<=1 on the edge with sync_idx=0, otherwise 0.
  - The edge with sync_idx=SYNC_LEN-1 moves to PAYLOAD with pay_cnt=0 and gap=0.
- PAYLOAD, on a transfer:
  - data_out<=data_in, data_out_valid<=1, gap<=0, pay_cnt++.
  - If pay_cnt was FRAME_BITS-1: frame_count++ and go to IDLE.
- PAYLOAD, no transfer:
  - data_out_valid<=0, gap++.
  - If gap reaches PAD_TIMEOUT-1 on this edge, go to PAD. PAD is entered after PAD_TIMEOUT consecutive idle cycles.
- PAD:
  - data_in_ready=0.
  - Each edge: data_out<=0, data_out_valid<=1, pay_cnt++.
  - On the edge completing pay_cnt=FRAME_BITS-1: frame_padded<=1, frame_count++, go to IDLE.
- Latency: data_valid seen in IDLE at edge E0 → sync bits on data_out after edges E1..E(SYNC_LEN). data_in_ready is high from E(SYNC_LEN). First payload bit appears on data_out after edge E(SYNC_LEN+1).
- Frame length on the wire is always SYNC_LEN+FRAME_BITS valid bits. Stall cycles in PAYLOAD appear as data_out_valid=0 gaps.
- Back-to-back frames: data_valid held high gives exactly one IDLE cycle (data_out_valid=0) between the last payload bit and the next sync bit 0.
- data_valid dropping during SYNC has no effect; the sync word always completes.
- A gap of exactly PAD_TIMEOUT-1 cycles followed by valid data does not pad; the gap counter resets on every transfer.
- frame_count wrap: 2^CNT_W-1 → 0 with no flag.

Decomposition:
- Shared package (shared with the frame synchronizer so both ends agree):
  - state enum (IDLE, SYNC, PAYLOAD, PAD)
  - SYNC_WORD/SYNC_LEN defaults
  - FRAME_BITS default
- Single module. No sub-module needed; the counters and FSM fit in one block.

Test Plan:
- Continuous stream, 56 bits of 0xFC61_8790 encoded, data_valid held high → data_out = 1110010 then the 56 bits in order. frame_start at the first bit. frame_count=1. data_in_ready high for exactly 56 cycles.
- Two frames back-to-back → exactly one data_out_valid=0 cycle between frames. Second frame_start 64 cycles after the first. frame_count=2.
- data_valid low for 15 cycles after payload bit 20, then resumed → no padding. 15-cycle valid gap on output. frame_count=1, frame_padded never 1.
- data_valid low permanently after payload bit 20 → after 16 idle cycles, 36 zero bits with valid=1. frame_padded pulses on the last of them. frame_count=1. State returns to IDLE.
- rst asserted mid-payload (bit 30) between clock edges → outputs clear immediately without a clock edge. After release, the next data_valid starts a fresh sync word. frame_count=0.
- Frame synchronizer loopback (encoder → this block → frame synchronizer) → synchronizer locks within 2 frames. Decoded words match the sent words.
